// File: rtl/filter_pkg.sv
// -----------------------------------------------------------------------------
// filter_pkg
// Types and constants shared by the filter output capture logic.
//   SAMPLE_W / FRAC_W : sfix10_En3 sample format
//   CAP_DEPTH         : default number of samples captured per run
//   cap_state_t       : capture controller states
//   SAMPLE_MAX/MIN    : extreme sfix10_En3 codes, used to seed the stats
// -----------------------------------------------------------------------------
package filter_pkg;

  localparam int SAMPLE_W  = 10;
  localparam int FRAC_W    = 3;
  localparam int CAP_DEPTH = 2000;

  localparam logic [SAMPLE_W-1:0] SAMPLE_MAX = 10'h1FF;  // +63.875
  localparam logic [SAMPLE_W-1:0] SAMPLE_MIN = 10'h200;  // -64.0

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP    = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } cap_state_t;

  // Two's-complement "a < b" on raw sample codes.
  function automatic logic sample_lt(input logic [SAMPLE_W-1:0] a,
                                     input logic [SAMPLE_W-1:0] b);
    return ($signed(a) < $signed(b));
  endfunction

endpackage

// File: rtl/filter_capture_if.sv
// -----------------------------------------------------------------------------
// filter_capture_if
// Valid/ready read port carrying captured samples out of filter_capture.
//   rd_valid : rd_data holds a captured sample
//   rd_ready : consumer accepts rd_data
//   rd_data  : captured sample, signed sfix10_En3
//   rd_last  : marks the final sample of the buffer
// master = producer (filter_capture), slave = consumer.
// -----------------------------------------------------------------------------
interface filter_capture_if;
  import filter_pkg::*;

  logic                rd_valid;
  logic                rd_ready;
  logic [SAMPLE_W-1:0] rd_data;
  logic                rd_last;

  modport master (
    output rd_valid,
    output rd_data,
    output rd_last,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    input  rd_last,
    output rd_ready
  );

endinterface

// File: rtl/filter_capture_ram.sv
// -----------------------------------------------------------------------------
// capture_ram
// Simple dual-port sample buffer: one write port, one synchronous read port.
// The array is not reset; contents are only meaningful once written.
//   clk   : clock
//   we    : write enable, waddr/wdata : write address/data
//   re    : read enable,  raddr       : read address
//   rdata : registered read data, holds while re=0
// -----------------------------------------------------------------------------
module capture_ram
  import filter_pkg::*;
#(
  parameter int DEPTH = CAP_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [SAMPLE_W-1:0] wdata,
  input  logic                re,
  input  logic [AW-1:0]       raddr,
  output logic [SAMPLE_W-1:0] rdata
);

  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [SAMPLE_W-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Synchronous read port; output holds when not enabled.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/filter_capture.sv
// -----------------------------------------------------------------------------
// filter_capture
// Captures DEPTH filter output samples (after an optional skip window) on
// clk_enable strobes, tracks their signed min/max, then drains the buffer
// in order through a valid/ready read port.
//   clk, resetn  : clock, synchronous active-low reset
//   clk_enable   : sample strobe shared with the filter
//   output_rsvd  : filter output sample (sfix10_En3)
//   start        : arm pulse, honoured in IDLE only
//   skip_count   : enabled samples to discard, sampled with start
//   busy, done   : run in progress / run completed
//   rd           : read port (rd_valid, rd_ready, rd_data, rd_last)
//   min_val, max_val : signed extremes of the samples captured this run
// -----------------------------------------------------------------------------
module filter_capture
  import filter_pkg::*;
#(
  parameter  int DEPTH = CAP_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                clk_enable,
  input  logic [SAMPLE_W-1:0] output_rsvd,
  input  logic                start,
  input  logic [7:0]          skip_count,
  output logic                busy,
  output logic                done,
  filter_capture_if.master    rd,
  output logic [SAMPLE_W-1:0] min_val,
  output logic [SAMPLE_W-1:0] max_val
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  cap_state_t          state_q,    state_d;
  logic [7:0]          skip_q,     skip_d;
  logic [AW-1:0]       wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q,   rd_ptr_d;    // index held in the RAM read register
  logic [SAMPLE_W-1:0] min_q,      min_d;
  logic [SAMPLE_W-1:0] max_q,      max_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;
  logic                rd_valid_q, rd_valid_d;
  logic [SAMPLE_W-1:0] rd_data_q,  rd_data_d;
  logic                rd_last_q,  rd_last_d;

  logic                ram_we_s;
  logic                ram_re_s;
  logic [AW-1:0]       ram_raddr_s;
  logic [SAMPLE_W-1:0] ram_rdata_s;
  logic                load_s;

  capture_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (wr_ptr_q),
    .wdata (output_rsvd),
    .re    (ram_re_s),
    .raddr (ram_raddr_s),
    .rdata (ram_rdata_s)
  );

  // Next-state, datapath and RAM control for the capture controller.
  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    min_d       = min_q;
    max_d       = max_q;
    done_d      = done_q;
    rd_valid_d  = rd_valid_q;
    rd_data_d   = rd_data_q;
    rd_last_d   = rd_last_q;
    ram_we_s    = 1'b0;
    ram_re_s    = 1'b0;
    ram_raddr_s = {AW{1'b0}};
    load_s      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          skip_d   = skip_count;
          wr_ptr_d = {AW{1'b0}};
          rd_ptr_d = {AW{1'b0}};
          min_d    = SAMPLE_MAX;
          max_d    = SAMPLE_MIN;
          done_d   = 1'b0;
          if (skip_count != 8'd0) begin
            state_d = SKIP;
          end else begin
            state_d = CAPTURE;
          end
        end else begin
          state_d = IDLE;
        end
      end

      SKIP: begin
        if (clk_enable) begin
          skip_d = skip_q - 8'd1;
          if (skip_q == 8'd1) begin
            state_d = CAPTURE;
          end else begin
            state_d = SKIP;
          end
        end else begin
          state_d = SKIP;
        end
      end

      CAPTURE: begin
        if (clk_enable) begin
          ram_we_s = 1'b1;
          if (sample_lt(output_rsvd, min_q)) begin
            min_d = output_rsvd;
          end else begin
            min_d = min_q;
          end
          if (sample_lt(max_q, output_rsvd)) begin
            max_d = output_rsvd;
          end else begin
            max_d = max_q;
          end
          if (wr_ptr_q == LAST_IDX) begin
            // Prefetch buf[0] on the final write edge so the first sample
            // can be registered out one cycle after entering DRAIN.
            state_d     = DRAIN;
            ram_re_s    = 1'b1;
            ram_raddr_s = {AW{1'b0}};
            rd_ptr_d    = {AW{1'b0}};
          end else begin
            wr_ptr_d = wr_ptr_q + AW'(1);
          end
        end else begin
          state_d = CAPTURE;
        end
      end

      DRAIN: begin
        // Load the output register when it is empty or being emptied, as
        // long as the last sample has not been loaded yet.
        load_s = !rd_last_q && (!rd_valid_q || rd.rd_ready);
        if (load_s) begin
          rd_data_d  = ram_rdata_s;
          rd_valid_d = 1'b1;
          rd_last_d  = (rd_ptr_q == LAST_IDX);
          if (rd_ptr_q != LAST_IDX) begin
            ram_re_s    = 1'b1;
            ram_raddr_s = rd_ptr_q + AW'(1);
            rd_ptr_d    = rd_ptr_q + AW'(1);
          end else begin
            rd_ptr_d = rd_ptr_q;
          end
        end else if (rd_valid_q && rd.rd_ready) begin
          // Only reachable with rd_last_q set: final transfer.
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Controller, pointer, stats and read-output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      skip_q     <= 8'd0;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      min_q      <= SAMPLE_MAX;
      max_q      <= SAMPLE_MIN;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= {SAMPLE_W{1'b0}};
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      min_q      <= min_d;
      max_q      <= max_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_last_q  <= rd_last_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign min_val     = min_q;
  assign max_val     = max_q;
  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_data  = rd_data_q;
  assign rd.rd_last  = rd_last_q;

endmodule

// File: tb/tb_filter_capture.sv
// -----------------------------------------------------------------------------
// tb_filter_capture
// Directed + randomized bench for filter_capture with DEPTH=8. A queue-based
// model records which samples should be stored (skip window, enable gaps)
// and derives drain order and signed min/max from that queue.
// -----------------------------------------------------------------------------
module tb_filter_capture;

  localparam int D = 8;

  logic       clk;
  logic       resetn;
  logic       clk_enable;
  logic [9:0] output_rsvd;
  logic       start;
  logic [7:0] skip_count;
  logic       busy;
  logic       done;
  logic [9:0] min_val;
  logic [9:0] max_val;

  filter_capture_if rd_if ();

  filter_capture #(.DEPTH(D)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .clk_enable  (clk_enable),
    .output_rsvd (output_rsvd),
    .start       (start),
    .skip_count  (skip_count),
    .busy        (busy),
    .done        (done),
    .rd          (rd_if),
    .min_val     (min_val),
    .max_val     (max_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // en_mode: 0 always, 1 alternating 1/0, 2 random
  // dat_mode: 0 base+cycle, 1 random, 2 random with extremes at cycles 2 and 5
  task automatic run_capture(input int skip, input int en_mode, input int dat_mode,
                             input logic [9:0] base, input bit poke_start);
    int k;
    int skipped;
    logic e;
    logic [9:0] dv;
    logic [9:0] mn;
    logic [9:0] mx;
    k = 0;
    skipped = 0;
    exp_q.delete();
    start = 1'b1;
    skip_count = skip[7:0];
    clk_enable = 1'b1;
    output_rsvd = 10'h3FF;  // coincident with start: must not be captured
    tick();
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("done_cleared", {31'd0, done}, 32'd0);
    while (exp_q.size() < D && k < 100) begin
      case (en_mode)
        0: e = 1'b1;
        1: e = (k % 2 == 0);
        default: e = 1'($urandom_range(0, 1));
      endcase
      case (dat_mode)
        0: dv = base + 10'(k);
        1: dv = 10'($urandom_range(0, 1023));
        default: begin
          if (k == 2) dv = 10'h200;
          else if (k == 5) dv = 10'h1FF;
          else dv = 10'($urandom_range(0, 1023));
        end
      endcase
      clk_enable = e;
      output_rsvd = dv;
      start = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      if (e) begin
        if (skipped < skip) skipped++;
        else exp_q.push_back(dv);
      end
      k++;
    end
    start = 1'b0;
    clk_enable = 1'b0;
    check("capture_count", exp_q.size(), D);
    check("busy_in_drain", {31'd0, busy}, 32'd1);
    check("no_valid_at_drain_entry", {31'd0, rd_if.rd_valid}, 32'd0);
    if (exp_q.size() > 0) begin
      mn = exp_q[0];
      mx = exp_q[0];
      foreach (exp_q[i]) begin
        if ($signed(exp_q[i]) < $signed(mn)) mn = exp_q[i];
        if ($signed(exp_q[i]) > $signed(mx)) mx = exp_q[i];
      end
      check("min_val", {22'd0, min_val}, {22'd0, mn});
      check("max_val", {22'd0, max_val}, {22'd0, mx});
    end
  endtask

  task automatic run_drain(input bit random_ready);
    int n_got;
    int cyc;
    logic ready;
    logic v;
    logic l;
    logic [9:0] d;
    logic prev_stall;
    logic [9:0] prev_data;
    logic prev_last;
    n_got = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_data = 10'd0;
    prev_last = 1'b0;
    while (n_got < D && cyc < 200) begin
      ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      rd_if.rd_ready = ready;
      clk_enable = 1'($urandom_range(0, 1));  // ignored while draining
      output_rsvd = 10'($urandom_range(0, 1023));
      if (cyc == 1) check("first_valid_latency", {31'd0, rd_if.rd_valid}, 32'd1);
      if (prev_stall) begin
        check("stall_valid", {31'd0, rd_if.rd_valid}, 32'd1);
        check("stall_data", {22'd0, rd_if.rd_data}, {22'd0, prev_data});
        check("stall_last", {31'd0, rd_if.rd_last}, {31'd0, prev_last});
      end
      v = rd_if.rd_valid;
      d = rd_if.rd_data;
      l = rd_if.rd_last;
      tick();
      cyc++;
      if (v && ready) begin
        check("drain_data", {22'd0, d}, {22'd0, exp_q[n_got]});
        check("drain_last", {31'd0, l}, {31'd0, (n_got == D - 1)});
        n_got++;
      end
      prev_stall = v && !ready;
      prev_data = d;
      prev_last = l;
    end
    rd_if.rd_ready = 1'b0;
    clk_enable = 1'b0;
    check("drain_count", n_got, D);
    check("valid_drop_after_last", {31'd0, rd_if.rd_valid}, 32'd0);
    check("busy_drop_after_last", {31'd0, busy}, 32'd0);
    check("done_after_last", {31'd0, done}, 32'd1);
    tick();
    check("done_holds", {31'd0, done}, 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_valid"}, {31'd0, rd_if.rd_valid}, 32'd0);
    check({tag, "_last"}, {31'd0, rd_if.rd_last}, 32'd0);
    check({tag, "_data"}, {22'd0, rd_if.rd_data}, 32'd0);
    check({tag, "_min"}, {22'd0, min_val}, 32'h1FF);
    check({tag, "_max"}, {22'd0, max_val}, 32'h200);
  endtask

  initial begin
    resetn = 1'b0;
    clk_enable = 1'b0;
    output_rsvd = 10'd0;
    start = 1'b0;
    skip_count = 8'd0;
    rd_if.rd_ready = 1'b0;
    tick();
    tick();
    check_reset_state("reset");
    resetn = 1'b1;
    tick();

    // Ramp 0..7
    run_capture(0, 0, 0, 10'h000, 1'b0);
    run_drain(1'b0);

    // Skip window of 3, input 0x10..
    run_capture(3, 0, 0, 10'h010, 1'b0);
    run_drain(1'b0);

    // Alternating enable, stray start pulses during capture
    run_capture(0, 1, 0, 10'h040, 1'b1);
    run_drain(1'b0);

    // Backpressure with random enables and data
    run_capture(2, 2, 1, 10'h000, 1'b0);
    run_drain(1'b1);

    // Extremes
    run_capture(0, 0, 2, 10'h000, 1'b0);
    check("extreme_min", {22'd0, min_val}, 32'h200);
    check("extreme_max", {22'd0, max_val}, 32'h1FF);
    run_drain(1'b1);

    // Reset after 4 of 8 samples
    start = 1'b1;
    skip_count = 8'd0;
    tick();
    start = 1'b0;
    clk_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      output_rsvd = 10'(i + 100);
      tick();
    end
    check("mid_busy_before_reset", {31'd0, busy}, 32'd1);
    resetn = 1'b0;
    tick();
    check_reset_state("midreset");
    resetn = 1'b1;
    clk_enable = 1'b0;
    tick();
    check("idle_after_reset", {31'd0, busy}, 32'd0);

    run_capture(0, 0, 0, 10'h000, 1'b0);
    run_drain(1'b0);

    // A few fully random runs
    for (int r = 0; r < 3; r++) begin
      run_capture(int'($urandom_range(0, 5)), 2, 1, 10'h000, 1'b1);
      run_drain(1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/filter_capture.md
# filter_capture

Synthesizable sink for the filter's output stream. While armed, it records sfix10_En3 output samples on every cycle where clk_enable is high, optionally discarding an initial latency window. It then streams the captured buffer out through a valid/ready read port for on-chip comparison or host readout. It also tracks running min/max of the captured samples. It sits directly after `filter` and taps the same clk_enable that gates the filter.

## Interface
Parameters:
- DEPTH, 2000: number of samples captured per run (≥2).
- AW, $clog2(DEPTH): buffer address width (derived, not overridden).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- clk_enable  in  1  sample strobe; same signal that enables the filter.
- output_rsvd  in  10  signed sfix10_En3 filter output.
- start  in  1  one-cycle arm pulse; honoured only in IDLE.
- skip_count  in  8  enabled samples to discard before storing; sampled with start.
- busy  out  1  high in SKIP, CAPTURE, DRAIN.
- done  out  1  high in IDLE after a completed drain; cleared by start or reset.
- rd_valid  out  1  rd_data holds a captured sample.
- rd_ready  in  1  consumer accepts rd_data.
- rd_data  out  10  captured sample, signed sfix10_En3.
- rd_last  out  1  qualifies the final sample (index DEPTH-1).
- min_val  out  10  smallest sample captured in this run.
- max_val  out  10  largest sample captured in this run.

## Operation
- States: IDLE, SKIP, CAPTURE, DRAIN.
- IDLE: when start=1, latch skip_count, clear wr_ptr/rd_ptr, set min_val=10'h1FF and max_val=10'h200, clear done. Next state is SKIP if skip_count≠0, else CAPTURE.
- SKIP: each edge with clk_enable=1 decrements the skip counter. The state moves to CAPTURE on the edge where the counter reaches 0. Skipped samples are neither stored nor counted in the stats.
- CAPTURE: each edge with clk_enable=1 writes output_rsvd to buf[wr_ptr], increments wr_ptr, and updates min/max with a signed compare. When clk_enable=0, nothing is written and no state changes. The write at wr_ptr=DEPTH-1 moves the state to DRAIN; wr_ptr does not wrap.
- DRAIN: presents buf[0..DEPTH-1] in order. A transfer occurs when rd_valid&rd_ready. rd_last=1 only with index DEPTH-1. The transfer of the last sample moves the state to IDLE and sets done=1.
- clk_enable is ignored outside SKIP and CAPTURE.
- start is ignored when not in IDLE.
- Arithmetic: samples are stored unmodified. Compares are 10-bit signed and there is no scaling.
- Reset (resetn=0 at an edge), from any state including mid-run:
  - state=IDLE; busy, done, rd_valid, rd_last all 0; rd_data=0.
  - min_val=10'h1FF, max_val=10'h200; pointers cleared.
  - Buffer contents are undefined afterwards. A new start behaves normally.

## Timing
- start at edge N: busy=1 from N+1. A clk_enable coincident with the start cycle is not captured.
- Capture latency: a sample present at edge N is in the buffer after N. min/max reflect it from N+1.
- Drain entry: the last write at edge N gives DRAIN from N+1 (synchronous RAM prefetch), with rd_valid=1 and rd_data=buf[0] from N+2.
- Throughput: one sample per cycle while rd_ready=1.
- Backpressure: while rd_valid=1 and rd_ready=0, rd_data and rd_last hold stable.
- rd_valid drops, busy drops, and done rises in the cycle after the last transfer.
- A full run takes at least skip_count+DEPTH enabled cycles, plus DEPTH+1 drain cycles.

## Structure
- Shared package `filter_pkg`:
  - SAMPLE_W=10, FRAC_W=3, DEPTH default 2000.
  - State enum cap_state_t {IDLE, SKIP, CAPTURE, DRAIN}.
  - Constants SAMPLE_MAX=10'h1FF and SAMPLE_MIN=10'h200.
- One sub-module, `capture_ram`: simple dual-port, DEPTH×10, one write port, one synchronous read port, no reset on the array.
- FSM, pointers, stats and the read output register live in `filter_capture`.

## Test plan
- Ramp: bench DEPTH=8, skip_count=0, clk_enable=1 continuously, input 0..7. Drain must give 0..7, rd_last with 7, min_val=0, max_val=7, and done=1 one cycle after the last transfer.
- Skip: DEPTH=8, skip_count=3, input 0x10..0x1A. The first three (0x10–0x12) are dropped; drain must give 0x13..0x1A.
- Enable gaps: clk_enable alternating 1/0, data incrementing every cycle. Only the enabled-cycle values are stored, in order, with no duplicates.
- Backpressure: random rd_ready during drain. rd_data must stay stable while stalled, and the full sequence must arrive exactly once.
- Extremes: samples include 10'h200 (−64.0) and 10'h1FF (+63.875). Expect min_val=10'h200 and max_val=10'h1FF.
- Reset mid-capture: resetn=0 after 4 of 8 samples. On the next edge busy=0, done=0, rd_valid=0. A subsequent start/ramp run must pass.
